// File: rtl/add_f32_sync.sv
// Single-precision IEEE-754 adder, round-to-nearest-even, subnormals flushed to zero.
// The combinational align/add/normalise/round core feeds a single output register stage.
module add_f32_sync #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned EXPONENTWIDTH = 8,
    parameter int unsigned MANTISSAWIDTH = 23
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic [WIDTH-1:0]           sum,
    output logic [EXPONENTWIDTH-1:0]   exp_diff,
    output logic [EXPONENTWIDTH-1:0]   in_exp,
    output logic [EXPONENTWIDTH-1:0]   sum_exp,
    output logic [MANTISSAWIDTH+1:0]   out1_mant,
    output logic [MANTISSAWIDTH+1:0]   out2_mant,
    output logic [MANTISSAWIDTH+1:0]   mant_sum,
    output logic [MANTISSAWIDTH+1:0]   sum_mant,
    output logic [4:0]                 mant_sum_shift
);

    logic        sa, sb, sl, ss;
    logic [7:0]  ea, eb, el, es, d;
    logic [22:0] fa, fb, fl, fs;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [23:0] ml, ms, al, nm, fm;
    logic [49:0] wide;
    logic        g, r, st, g2, r2, s2, rnd;
    logic [27:0] ext_l, ext_s, raw;
    logic [26:0] sh;
    logic [4:0]  lz;
    logic [24:0] mr;
    logic signed [9:0] e_n, e_f;

    logic [31:0] sum_d, sum_q;
    logic [7:0]  exp_diff_d, exp_diff_q, in_exp_d, in_exp_q, sum_exp_d, sum_exp_q;
    logic [24:0] out1_mant_d, out1_mant_q, out2_mant_d, out2_mant_q;
    logic [24:0] mant_sum_d, mant_sum_q, sum_mant_d, sum_mant_q;
    logic [4:0]  mant_sum_shift_d, mant_sum_shift_q;

    assign sa = a[31];
    assign ea = a[30:23];
    assign fa = a[22:0];
    assign sb = b[31];
    assign eb = b[30:23];
    assign fb = b[22:0];

    always_comb begin
        a_nan = (ea == 8'hFF) && (fa != 23'd0);
        b_nan = (eb == 8'hFF) && (fb != 23'd0);
        a_inf = (ea == 8'hFF) && (fa == 23'd0);
        b_inf = (eb == 8'hFF) && (fb == 23'd0);

        // Order by magnitude; the larger operand fixes sign and base exponent.
        if ({ea, fa} >= {eb, fb}) begin
            sl = sa; el = ea; fl = fa;
            ss = sb; es = eb; fs = fb;
        end else begin
            sl = sb; el = eb; fl = fb;
            ss = sa; es = ea; fs = fa;
        end
        d  = el - es;
        ml = {1'b1, fl};
        ms = {1'b1, fs};

        // 26 extra bits below the mantissa keep every shifted-out bit for diffs up to 25.
        wide = {ms, 26'd0} >> d;
        if (d >= 8'd26) begin
            al = 24'd0;
            g  = 1'b0;
            r  = 1'b0;
            st = 1'b1;
        end else begin
            al = wide[49:26];
            g  = wide[25];
            r  = wide[24];
            st = |wide[23:0];
        end

        ext_l = {1'b0, ml, 3'b000};
        ext_s = {1'b0, al, g, r, st};
        raw   = (sl == ss) ? (ext_l + ext_s) : (ext_l - ext_s);

        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (raw[i]) lz = 5'(26 - i);
        end

        sh = 27'd0;
        if (raw[27]) begin
            nm  = raw[27:4];
            g2  = raw[3];
            r2  = raw[2];
            s2  = |raw[1:0];
            e_n = $signed({2'b00, el}) + 10'sd1;
        end else begin
            sh  = raw[26:0] << lz;
            nm  = sh[26:3];
            g2  = sh[2];
            r2  = sh[1];
            s2  = sh[0];
            e_n = $signed({2'b00, el}) - $signed({5'b00000, lz});
        end

        rnd = g2 & (r2 | s2 | nm[0]);
        mr  = {1'b0, nm} + {24'd0, rnd};
        if (mr[24]) begin
            fm  = mr[24:1];
            e_f = e_n + 10'sd1;
        end else begin
            fm  = mr[23:0];
            e_f = e_n;
        end

        if (a_nan || b_nan) begin
            sum_d = 32'h7FFF_FFFF;
        end else if (a_inf && b_inf) begin
            sum_d = (sa != sb) ? 32'h7FFF_FFFF : a;
        end else if (a_inf) begin
            sum_d = a;
        end else if (b_inf) begin
            sum_d = b;
        end else if (ea == 8'd0 && eb == 8'd0) begin
            sum_d = {sa & sb, 31'd0};
        end else if (ea == 8'd0) begin
            sum_d = b;
        end else if (eb == 8'd0) begin
            sum_d = a;
        end else if (raw == 28'd0) begin
            sum_d = 32'd0;
        end else if (e_f >= 10'sd255) begin
            sum_d = {sl, 8'hFF, 23'd0};
        end else if (e_f <= 10'sd0) begin
            sum_d = {sl, 31'd0};
        end else begin
            sum_d = {sl, e_f[7:0], fm[22:0]};
        end

        exp_diff_d       = d;
        in_exp_d         = el;
        sum_exp_d        = sum_d[30:23];
        out1_mant_d      = {1'b0, ml};
        out2_mant_d      = {1'b0, al};
        mant_sum_d       = raw[27:3];
        sum_mant_d       = {1'b0, fm};
        mant_sum_shift_d = raw[27] ? 5'd0 : lz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q            <= '0;
            exp_diff_q       <= '0;
            in_exp_q         <= '0;
            sum_exp_q        <= '0;
            out1_mant_q      <= '0;
            out2_mant_q      <= '0;
            mant_sum_q       <= '0;
            sum_mant_q       <= '0;
            mant_sum_shift_q <= '0;
        end else begin
            sum_q            <= sum_d;
            exp_diff_q       <= exp_diff_d;
            in_exp_q         <= in_exp_d;
            sum_exp_q        <= sum_exp_d;
            out1_mant_q      <= out1_mant_d;
            out2_mant_q      <= out2_mant_d;
            mant_sum_q       <= mant_sum_d;
            sum_mant_q       <= sum_mant_d;
            mant_sum_shift_q <= mant_sum_shift_d;
        end
    end

    assign sum            = sum_q;
    assign exp_diff       = exp_diff_q;
    assign in_exp         = in_exp_q;
    assign sum_exp        = sum_exp_q;
    assign out1_mant      = out1_mant_q;
    assign out2_mant      = out2_mant_q;
    assign mant_sum       = mant_sum_q;
    assign sum_mant       = sum_mant_q;
    assign mant_sum_shift = mant_sum_shift_q;

endmodule

// File: tb/tb_add_f32_sync.sv
// Directed-vector bench for add_f32_sync: sums, debug taps, specials, extremes and reset.
module tb_add_f32_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b, sum;
    logic [7:0]  exp_diff, in_exp, sum_exp;
    logic [24:0] out1_mant, out2_mant, mant_sum, sum_mant;
    logic [4:0]  mant_sum_shift;

    int checks   = 0;
    int failures = 0;

    add_f32_sync dut (
        .clk            (clk),
        .rst            (rst),
        .a              (a),
        .b              (b),
        .sum            (sum),
        .exp_diff       (exp_diff),
        .in_exp         (in_exp),
        .sum_exp        (sum_exp),
        .out1_mant      (out1_mant),
        .out2_mant      (out2_mant),
        .mant_sum       (mant_sum),
        .sum_mant       (sum_mant),
        .mant_sum_shift (mant_sum_shift)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drive operands away from the edge, then sample just after the capturing edge.
    task automatic apply(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".sum"}, sum, 32'd0);
        check({tag, ".exp_diff"}, {24'd0, exp_diff}, 32'd0);
        check({tag, ".in_exp"}, {24'd0, in_exp}, 32'd0);
        check({tag, ".sum_exp"}, {24'd0, sum_exp}, 32'd0);
        check({tag, ".out1_mant"}, {7'd0, out1_mant}, 32'd0);
        check({tag, ".out2_mant"}, {7'd0, out2_mant}, 32'd0);
        check({tag, ".mant_sum"}, {7'd0, mant_sum}, 32'd0);
        check({tag, ".sum_mant"}, {7'd0, sum_mant}, 32'd0);
        check({tag, ".shift"}, {27'd0, mant_sum_shift}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        a   = 32'h3FC0_0000;
        b   = 32'h3E80_0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("por");

        rst = 1'b0;
        apply(32'h3FC0_0000, 32'h3E80_0000);
        check("add_1p5_0p25", sum, 32'h3FE0_0000);
        check("dbg1.exp_diff", {24'd0, exp_diff}, 32'd2);
        check("dbg1.in_exp", {24'd0, in_exp}, 32'h7F);
        check("dbg1.sum_exp", {24'd0, sum_exp}, 32'h7F);
        check("dbg1.out1_mant", {7'd0, out1_mant}, 32'h00C0_0000);
        check("dbg1.out2_mant", {7'd0, out2_mant}, 32'h0020_0000);
        check("dbg1.mant_sum", {7'd0, mant_sum}, 32'h00E0_0000);
        check("dbg1.sum_mant", {7'd0, sum_mant}, 32'h00E0_0000);
        check("dbg1.shift", {27'd0, mant_sum_shift}, 32'd0);

        // Output must hold until the next edge even when inputs change.
        @(negedge clk);
        a = 32'h3FC0_0000;
        b = 32'hC020_0000;
        #1;
        check("hold_before_edge", sum, 32'h3FE0_0000);
        @(posedge clk);
        #1;
        check("add_1p5_m2p5", sum, 32'hBF80_0000);
        check("dbg2.exp_diff", {24'd0, exp_diff}, 32'd1);
        check("dbg2.in_exp", {24'd0, in_exp}, 32'h80);
        check("dbg2.sum_exp", {24'd0, sum_exp}, 32'h7F);
        check("dbg2.out1_mant", {7'd0, out1_mant}, 32'h00A0_0000);
        check("dbg2.out2_mant", {7'd0, out2_mant}, 32'h0060_0000);
        check("dbg2.mant_sum", {7'd0, mant_sum}, 32'h0040_0000);
        check("dbg2.sum_mant", {7'd0, sum_mant}, 32'h0080_0000);
        check("dbg2.shift", {27'd0, mant_sum_shift}, 32'd1);

        apply(32'h3F70_971D, 32'hBDED_6FB2);
        check("round_sub", sum, 32'h3F52_E927);
        apply(32'h4F92_C660, 32'hBF7E_77E3);
        check("sticky_no_borrow", sum, 32'h4F92_C660);
        apply(32'hC3FA_0F5C, 32'h43FA_0F5C);
        check("cancel_neg_first", sum, 32'h0000_0000);
        apply(32'h3E88_36B8, 32'hBE88_36B8);
        check("cancel_pos_first", sum, 32'h0000_0000);
        apply(32'h0000_0000, 32'h0000_0000);
        check("zero_plus_zero", sum, 32'h0000_0000);
        apply(32'h40A0_0000, 32'h0000_0000);
        check("x_plus_zero", sum, 32'h40A0_0000);

        apply(32'h7FFF_FFFF, 32'h0000_0000);
        check("nan_plus_zero", sum, 32'h7FFF_FFFF);
        apply(32'h0000_0000, 32'h7F80_0000);
        check("zero_plus_inf", sum, 32'h7F80_0000);
        apply(32'h7FFF_FFFF, 32'h7F80_0000);
        check("nan_plus_inf", sum, 32'h7FFF_FFFF);
        apply(32'h7F80_0000, 32'hFF80_0000);
        check("inf_minus_inf", sum, 32'h7FFF_FFFF);

        apply(32'h7F7F_FFFF, 32'h00FF_FFFF);
        check("max_plus_tiny", sum, 32'h7F7F_FFFF);
        apply(32'h7F7F_FFFF, 32'h80FF_FFFF);
        check("max_minus_tiny", sum, 32'h7F7F_FFFF);
        apply(32'hFF7F_FFFF, 32'h00FF_FFFF);
        check("nmax_plus_tiny", sum, 32'hFF7F_FFFF);
        apply(32'hFF7F_FFFF, 32'h80FF_FFFF);
        check("nmax_minus_tiny", sum, 32'hFF7F_FFFF);
        apply(32'h7F7F_FFFF, 32'h7F7F_FFFF);
        check("overflow_inf", sum, 32'h7F80_0000);

        // Reset in the middle of traffic overrides the operands of that cycle.
        @(negedge clk);
        rst = 1'b1;
        apply(32'h3FC0_0000, 32'h3E80_0000);
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        apply(32'h3FC0_0000, 32'h3E80_0000);
        check("after_reset", sum, 32'h3FE0_0000);
        check("after_reset.in_exp", {24'd0, in_exp}, 32'h7F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
